// File: rtl/dma_task_sequencer_if.sv
// Task handshake between the DMA task sequencer and the AXI-Lite register-write master.
// slaveInit carries the pending one-hot task; slaveFinInit echoes it back for one cycle on completion.
interface dma_task_sequencer_if #(
    parameter int DMA_INIT_TASK_CNT = 8
);
    logic [DMA_INIT_TASK_CNT-1:0] slaveInit;
    logic [DMA_INIT_TASK_CNT-1:0] slaveFinInit;

    modport master (output slaveInit, input slaveFinInit);
    modport slave  (input slaveInit, output slaveFinInit);
endinterface

// File: rtl/dma_task_sequencer.sv
// DMA task sequencer: issues the enabled one-hot DMA init tasks in bit order,
// holding each until the write master echoes it, then waits for the MM2S/S2MM
// completion interrupts while profiling the wait in clock cycles.
module dma_task_sequencer #(
    parameter int DMA_INIT_TASK_CNT   = 8,
    parameter int BANK1_STATUS_WIDTH  = 2,
    parameter int BANK1_PROFILE_WIDTH = 32,
    parameter int TIMEOUT_CYCLES      = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           cfg_rd_en,
    input  logic                           cfg_wr_en,
    input  logic                           irq_mm2s,
    input  logic                           irq_s2mm,
    dma_task_sequencer_if.master           task_bus,
    output logic                           busy,
    output logic                           done,
    output logic [BANK1_STATUS_WIDTH-1:0]  status,
    output logic [BANK1_PROFILE_WIDTH-1:0] profile,
    output logic                           err_abort,
    output logic                           err_timeout
);
    localparam int N  = DMA_INIT_TASK_CNT;
    localparam int SW = BANK1_STATUS_WIDTH;
    localparam int PW = BANK1_PROFILE_WIDTH;

    // Read group: IRQ reset, ctrl, address, size of MM2S. Write group: the S2MM counterparts.
    localparam logic [N-1:0]  RD_GROUP     = N'(8'b0001_1101);
    localparam logic [N-1:0]  WR_GROUP     = N'(8'b1110_0010);
    localparam logic [N-1:0]  ZERO_N       = {N{1'b0}};
    localparam logic [N-1:0]  ONE_N        = {{(N-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] ZERO_P       = {PW{1'b0}};
    localparam logic [PW-1:0] ONE_P        = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PROFILE_MAX  = {PW{1'b1}};
    localparam logic [PW-1:0] TIMEOUT_LAST = PW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] ST_IDLE      = SW'(2'b00);
    localparam logic [SW-1:0] ST_BUSY      = SW'(2'b01);
    localparam logic [SW-1:0] ST_OK        = SW'(2'b10);
    localparam logic [SW-1:0] ST_ERR       = SW'(2'b11);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT_IRQ = 3'd2,
        S_DONE     = 3'd3,
        S_ERR      = 3'd4
    } state_t;

    // Isolates the lowest set bit of a vector.
    function automatic logic [N-1:0] lowest_bit(input logic [N-1:0] vec);
        lowest_bit = vec & (~vec + ONE_N);
    endfunction

    // Keeps only the bits of vec strictly above the one-hot position cur.
    function automatic logic [N-1:0] bits_above(input logic [N-1:0] vec, input logic [N-1:0] cur);
        bits_above = vec & ~((cur << 1) - ONE_N);
    endfunction

    state_t          state_r, state_s;
    logic [N-1:0]    task_r, task_s;
    logic [N-1:0]    mask_r, mask_s;
    logic            rd_req_r, rd_req_s;
    logic            wr_req_r, wr_req_s;
    logic            irq_rd_r, irq_rd_s;
    logic            irq_wr_r, irq_wr_s;
    logic            rd_arm_r, rd_arm_s;
    logic            wr_arm_r, wr_arm_s;
    logic            abort_pend_r, abort_pend_s;
    logic [PW-1:0]   profile_r, profile_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic [SW-1:0]   status_r, status_s;
    logic            err_abort_r, err_abort_s;
    logic            err_timeout_r, err_timeout_s;

    logic [N-1:0]    start_mask_s;
    logic [N-1:0]    next_task_s;
    logic            echo_match_s;
    logic            irq_done_s;
    logic            timeout_hit_s;

    assign start_mask_s  = (cfg_rd_en ? RD_GROUP : ZERO_N) | (cfg_wr_en ? WR_GROUP : ZERO_N);
    assign next_task_s   = lowest_bit(bits_above(mask_r, task_r));
    assign echo_match_s  = (task_bus.slaveFinInit == task_r);
    assign irq_done_s    = (!rd_req_r || irq_rd_r) && (!wr_req_r || irq_wr_r);
    assign timeout_hit_s = (TIMEOUT_CYCLES != 32'sd0) && (profile_r == TIMEOUT_LAST);

    // Next-state and next-register computation for the job sequencer.
    always_comb begin
        state_s       = state_r;
        task_s        = task_r;
        mask_s        = mask_r;
        rd_req_s      = rd_req_r;
        wr_req_s      = wr_req_r;
        irq_rd_s      = irq_rd_r;
        irq_wr_s      = irq_wr_r;
        rd_arm_s      = rd_arm_r;
        wr_arm_s      = wr_arm_r;
        abort_pend_s  = abort_pend_r;
        profile_s     = profile_r;
        busy_s        = busy_r;
        done_s        = 1'b0;
        status_s      = status_r;
        err_abort_s   = err_abort_r;
        err_timeout_s = err_timeout_r;

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    mask_s        = start_mask_s;
                    rd_req_s      = cfg_rd_en;
                    wr_req_s      = cfg_wr_en;
                    irq_rd_s      = 1'b0;
                    irq_wr_s      = 1'b0;
                    rd_arm_s      = 1'b0;
                    wr_arm_s      = 1'b0;
                    abort_pend_s  = 1'b0;
                    profile_s     = ZERO_P;
                    err_abort_s   = 1'b0;
                    err_timeout_s = 1'b0;
                    if (start_mask_s == ZERO_N) begin
                        // Nothing to configure: the job is trivially complete.
                        state_s  = S_DONE;
                        task_s   = ZERO_N;
                        status_s = ST_OK;
                        busy_s   = 1'b0;
                        done_s   = 1'b1;
                    end else begin
                        state_s  = S_ISSUE;
                        task_s   = lowest_bit(start_mask_s);
                        status_s = ST_BUSY;
                        busy_s   = 1'b1;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end

            S_ISSUE: begin
                // IRQ latches only become meaningful once the matching IRQ-reset task has completed.
                if (rd_arm_r && irq_mm2s) begin
                    irq_rd_s = 1'b1;
                end else begin
                    irq_rd_s = irq_rd_r;
                end
                if (wr_arm_r && irq_s2mm) begin
                    irq_wr_s = 1'b1;
                end else begin
                    irq_wr_s = irq_wr_r;
                end
                if (echo_match_s) begin
                    rd_arm_s = rd_arm_r | task_r[0];
                    wr_arm_s = wr_arm_r | task_r[1];
                    if (abort || abort_pend_r) begin
                        // The in-flight task has finished cleanly; stop before issuing more.
                        state_s      = S_ERR;
                        task_s       = ZERO_N;
                        abort_pend_s = 1'b0;
                        err_abort_s  = 1'b1;
                        status_s     = ST_ERR;
                        busy_s       = 1'b0;
                        done_s       = 1'b1;
                    end else if (next_task_s == ZERO_N) begin
                        state_s = S_WAIT_IRQ;
                        task_s  = ZERO_N;
                    end else begin
                        task_s = next_task_s;
                    end
                end else begin
                    abort_pend_s = abort_pend_r | abort;
                end
            end

            S_WAIT_IRQ: begin
                irq_rd_s = irq_rd_r | irq_mm2s;
                irq_wr_s = irq_wr_r | irq_s2mm;
                if (irq_done_s) begin
                    state_s  = S_DONE;
                    status_s = ST_OK;
                    busy_s   = 1'b0;
                    done_s   = 1'b1;
                end else if (timeout_hit_s) begin
                    state_s       = S_ERR;
                    err_timeout_s = 1'b1;
                    status_s      = ST_ERR;
                    busy_s        = 1'b0;
                    done_s        = 1'b1;
                end else if (abort) begin
                    state_s     = S_ERR;
                    err_abort_s = 1'b1;
                    status_s    = ST_ERR;
                    busy_s      = 1'b0;
                    done_s      = 1'b1;
                end else begin
                    if (profile_r != PROFILE_MAX) begin
                        profile_s = profile_r + ONE_P;
                    end else begin
                        profile_s = profile_r;
                    end
                end
            end

            S_DONE: begin
                state_s = S_IDLE;
            end

            S_ERR: begin
                state_s = S_IDLE;
            end

            default: begin
                state_s  = S_IDLE;
                task_s   = ZERO_N;
                busy_s   = 1'b0;
                status_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Task, latch, profile and status registers; every output comes straight from here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            task_r        <= ZERO_N;
            mask_r        <= ZERO_N;
            rd_req_r      <= 1'b0;
            wr_req_r      <= 1'b0;
            irq_rd_r      <= 1'b0;
            irq_wr_r      <= 1'b0;
            rd_arm_r      <= 1'b0;
            wr_arm_r      <= 1'b0;
            abort_pend_r  <= 1'b0;
            profile_r     <= ZERO_P;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            status_r      <= ST_IDLE;
            err_abort_r   <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            task_r        <= task_s;
            mask_r        <= mask_s;
            rd_req_r      <= rd_req_s;
            wr_req_r      <= wr_req_s;
            irq_rd_r      <= irq_rd_s;
            irq_wr_r      <= irq_wr_s;
            rd_arm_r      <= rd_arm_s;
            wr_arm_r      <= wr_arm_s;
            abort_pend_r  <= abort_pend_s;
            profile_r     <= profile_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            status_r      <= status_s;
            err_abort_r   <= err_abort_s;
            err_timeout_r <= err_timeout_s;
        end
    end

    assign task_bus.slaveInit = task_r;
    assign busy               = busy_r;
    assign done               = done_r;
    assign status             = status_r;
    assign profile            = profile_r;
    assign err_abort          = err_abort_r;
    assign err_timeout        = err_timeout_r;
endmodule

// File: tb/tb_dma_task_sequencer.sv
// Testbench for dma_task_sequencer: directed scenarios plus randomized jobs, each
// checked against a job-level model (task order from the group table, exit cycle
// and outcome from the IRQ/abort/timeout times).
module tb_dma_task_sequencer;
    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        cfg_rd_en;
    logic        cfg_wr_en;
    logic        irq_mm2s;
    logic        irq_s2mm;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [31:0] profile;
    logic        err_abort;
    logic        err_timeout;

    int total = 0;
    int bad   = 0;

    dma_task_sequencer_if #(.DMA_INIT_TASK_CNT(8)) bus ();

    dma_task_sequencer #(
        .DMA_INIT_TASK_CNT  (8),
        .BANK1_STATUS_WIDTH (2),
        .BANK1_PROFILE_WIDTH(32),
        .TIMEOUT_CYCLES     (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .cfg_rd_en  (cfg_rd_en),
        .cfg_wr_en  (cfg_wr_en),
        .irq_mm2s   (irq_mm2s),
        .irq_s2mm   (irq_s2mm),
        .task_bus   (bus),
        .busy       (busy),
        .done       (done),
        .status     (status),
        .profile    (profile),
        .err_abort  (err_abort),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    // Read-channel tasks: IRQ reset, ctrl, address, size of MM2S.
    function automatic bit is_read_task(input int b);
        return (b == 0) || (b == 2) || (b == 3) || (b == 4);
    endfunction

    // One job. t_rd/t_wr: WAIT cycle of the IRQ pulse (-1 none). ab_bit: raise abort while
    // that task is pending. ab_wait: WAIT cycle from which abort is held. rst_at: WAIT cycle
    // in which reset is pulled low (-1 none).
    task automatic run_job(input string name, input bit rd, input bit wr, input int dly,
                           input int t_rd, input int t_wr, input logic [7:0] ab_bit,
                           input int ab_wait, input bit wrong_echo, input bit busy_start,
                           input int rst_at);
        logic [7:0] plan[$];
        logic [7:0] one_hot;
        logic [7:0] pend;
        int idx;
        int hold;
        int c;
        int e;
        int kind;
        bit aborted;

        for (int b = 0; b < 8; b++) begin
            one_hot = 8'h01 << b;
            if ((rd && is_read_task(b)) || (wr && !is_read_task(b))) plan.push_back(one_hot);
        end

        @(negedge clk);
        cfg_rd_en = rd;
        cfg_wr_en = wr;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        cfg_rd_en = ~rd;
        cfg_wr_en = ~wr;

        if (plan.size() == 0) begin
            check({name, ":empty_done"}, done, 1);
            check({name, ":empty_busy"}, busy, 0);
            check({name, ":empty_status"}, status, 2);
            check({name, ":empty_task"}, bus.slaveInit, 0);
            check({name, ":empty_profile"}, profile, 0);
            @(negedge clk);
            check({name, ":empty_done_end"}, done, 0);
            check({name, ":empty_status_hold"}, status, 2);
            return;
        end

        check({name, ":start_busy"}, busy, 1);
        check({name, ":start_status"}, status, 1);
        check({name, ":start_done"}, done, 0);

        idx     = 0;
        hold    = 0;
        aborted = 1'b0;
        while (idx < plan.size()) begin
            pend = plan[idx];
            check({name, ":task"}, bus.slaveInit, pend);
            check({name, ":issue_busy"}, busy, 1);
            if (ab_bit != 8'h00 && pend == ab_bit) abort = 1'b1;
            start = busy_start && (idx == 1) && (hold == 0);
            if (hold == dly) bus.slaveFinInit = pend;
            else if (wrong_echo && hold == 1) bus.slaveFinInit = {pend[6:0], pend[7]};
            else bus.slaveFinInit = 8'h00;
            @(negedge clk);
            start = 1'b0;
            if (hold == dly) begin
                hold = 0;
                idx++;
                if (abort) begin
                    aborted = 1'b1;
                    break;
                end
            end else begin
                hold++;
            end
        end
        bus.slaveFinInit = 8'h00;

        if (aborted) begin
            check({name, ":abort_task"}, bus.slaveInit, 0);
            check({name, ":abort_done"}, done, 1);
            check({name, ":abort_busy"}, busy, 0);
            check({name, ":abort_status"}, status, 3);
            check({name, ":abort_flag"}, err_abort, 1);
            check({name, ":abort_tmo_flag"}, err_timeout, 0);
            check({name, ":abort_profile"}, profile, 0);
            abort = 1'b0;
            @(negedge clk);
            check({name, ":abort_done_end"}, done, 0);
            check({name, ":abort_status_hold"}, status, 3);
            check({name, ":abort_flag_hold"}, err_abort, 1);
            return;
        end

        // Job-level outcome: completion is visible the cycle after the last required IRQ.
        c = 1000000;
        if ((!rd || t_rd >= 0) && (!wr || t_wr >= 0)) begin
            c = 0;
            if (rd && t_rd + 1 > c) c = t_rd + 1;
            if (wr && t_wr + 1 > c) c = t_wr + 1;
        end
        if (c <= TMO - 1 && (ab_wait < 0 || c <= ab_wait)) begin
            e = c;
            kind = 0;
        end else if (ab_wait >= 0 && ab_wait < TMO - 1) begin
            e = ab_wait;
            kind = 1;
        end else begin
            e = TMO - 1;
            kind = 2;
        end

        for (int k = 0; k <= e; k++) begin
            check({name, ":wait_profile"}, profile, k);
            check({name, ":wait_task"}, bus.slaveInit, 0);
            check({name, ":wait_status"}, status, 1);
            check({name, ":wait_done"}, done, 0);
            if (k == rst_at) begin
                reset = 1'b0;
                #1;
                check({name, ":rst_busy"}, busy, 0);
                check({name, ":rst_status"}, status, 0);
                check({name, ":rst_profile"}, profile, 0);
                check({name, ":rst_task"}, bus.slaveInit, 0);
                check({name, ":rst_done"}, done, 0);
                @(negedge clk);
                reset    = 1'b1;
                irq_mm2s = 1'b0;
                irq_s2mm = 1'b0;
                abort    = 1'b0;
                return;
            end
            irq_mm2s = (k == t_rd);
            irq_s2mm = (k == t_wr);
            abort    = (ab_wait >= 0) && (k >= ab_wait);
            @(negedge clk);
        end
        irq_mm2s = 1'b0;
        irq_s2mm = 1'b0;
        abort    = 1'b0;

        check({name, ":end_done"}, done, 1);
        check({name, ":end_busy"}, busy, 0);
        check({name, ":end_status"}, status, (kind == 0) ? 2 : 3);
        check({name, ":end_profile"}, profile, e);
        check({name, ":end_err_abort"}, err_abort, (kind == 1) ? 1 : 0);
        check({name, ":end_err_timeout"}, err_timeout, (kind == 2) ? 1 : 0);
        check({name, ":end_task"}, bus.slaveInit, 0);
        @(negedge clk);
        check({name, ":end_done_pulse"}, done, 0);
        check({name, ":end_status_hold"}, status, (kind == 0) ? 2 : 3);
        check({name, ":end_profile_hold"}, profile, e);
    endtask

    initial begin
        bit         r_rd;
        bit         r_wr;
        bit         r_wrong;
        int         r_dly;
        int         r_trd;
        int         r_twr;
        int         r_abw;
        logic [7:0] r_abb;

        reset            = 1'b0;
        start            = 1'b0;
        abort            = 1'b0;
        cfg_rd_en        = 1'b0;
        cfg_wr_en        = 1'b0;
        irq_mm2s         = 1'b0;
        irq_s2mm         = 1'b0;
        bus.slaveFinInit = 8'h00;

        repeat (3) @(negedge clk);
        check("rst:task", bus.slaveInit, 0);
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:status", status, 0);
        check("rst:profile", profile, 0);
        check("rst:err_abort", err_abort, 0);
        check("rst:err_timeout", err_timeout, 0);
        reset = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort:status", status, 0);
        check("idle_abort:done", done, 0);

        run_job("full",        1'b1, 1'b1, 3, 10, 20, 8'h00, -1, 1'b0, 1'b0, -1);
        run_job("rd_only",     1'b1, 1'b0, 3, 10, -1, 8'h00, -1, 1'b0, 1'b0, -1);
        run_job("wr_only",     1'b0, 1'b1, 0, -1, 4,  8'h00, -1, 1'b0, 1'b0, -1);
        run_job("timeout",     1'b1, 1'b1, 1, -1, -1, 8'h00, -1, 1'b0, 1'b0, -1);
        run_job("abort_issue", 1'b1, 1'b1, 6, 5,  5,  8'h08, -1, 1'b0, 1'b0, -1);
        run_job("wrong_echo",  1'b1, 1'b1, 3, 2,  3,  8'h00, -1, 1'b1, 1'b1, -1);
        run_job("no_chan",     1'b0, 1'b0, 0, -1, -1, 8'h00, -1, 1'b0, 1'b0, -1);
        run_job("abort_wait",  1'b0, 1'b1, 0, -1, -1, 8'h00, 7,  1'b0, 1'b0, -1);
        run_job("abort_vs_ok", 1'b1, 1'b0, 1, 9,  -1, 8'h00, 10, 1'b0, 1'b0, -1);
        run_job("last_abort",  1'b0, 1'b1, 2, -1, -1, 8'h80, -1, 1'b0, 1'b0, -1);
        run_job("reset_mid",   1'b1, 1'b1, 1, -1, -1, 8'h00, -1, 1'b0, 1'b0, 5);
        check("post_rst:status", status, 0);
        check("post_rst:busy", busy, 0);
        run_job("after_rst",   1'b1, 1'b1, 2, 3,  6,  8'h00, -1, 1'b0, 1'b0, -1);

        for (int j = 0; j < 25; j++) begin
            r_rd    = 1'($urandom_range(0, 1));
            r_wr    = 1'($urandom_range(0, 1));
            r_dly   = int'($urandom_range(0, 4));
            r_trd   = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 55));
            r_twr   = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 55));
            r_abb   = ($urandom_range(0, 7) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            r_abw   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 45)) : -1;
            r_wrong = (r_dly >= 2) && ($urandom_range(0, 1) == 1);
            run_job("rand", r_rd, r_wr, r_dly, r_trd, r_twr, r_abb, r_abw, r_wrong, 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
